// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-8 serial deserializer.
// Lane index, word and control-state definitions.
package demux_pkg;

  localparam int DEMUX_WIDTH = 8;
  localparam int DEMUX_SEL_W = 3;

  typedef logic [DEMUX_SEL_W-1:0] sel_t;
  typedef logic [DEMUX_WIDTH-1:0] word_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/demux_lane_decoder.sv
// One-hot lane decode of the select index, gated by the bit strobe.
// Produces per-bit write enables for the shadow word.
module demux_lane_decoder
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int SEL_W = DEMUX_SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] we
);

  logic [WIDTH-1:0] one;

  assign one = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    we = '0;
    if (in_valid)
      we = one << sel;
  end

endmodule

// File: rtl/demultiplexer_1_to_8_deserializer.sv
// Serial-to-parallel receive end: LSB-first assembly of WIDTH bits
// into a shadow word, presented on output_lines with valid/ready.
module demultiplexer_1_to_8_deserializer
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int SEL_W = DEMUX_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_lines,
  output logic [SEL_W-1:0] select_lines,
  output logic             out_valid,
  output logic             overrun
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovr_q, ovr_d;
  state_t           state_q, state_d;

  logic [WIDTH-1:0] we;
  logic [WIDTH-1:0] wr_word;
  logic             accept;
  logic             done;
  logic             slot_free;

  assign accept = in_valid & ~clear;

  demux_lane_decoder #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_dec (
    .sel     (sel_q),
    .in_valid(accept),
    .we      (we)
  );

  assign wr_word = (shadow_q & ~we)
                 | ({WIDTH{serial_in}} & we);
  assign done = accept
              && (sel_q == SEL_W'(WIDTH-1));
  assign slot_free = (state_q == COLLECT)
                   || out_ready;

  always_comb begin
    sel_d    = sel_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    ovr_d    = ovr_q;
    state_d  = state_q;
    if (state_q == HOLD && out_ready)
      state_d = COLLECT;
    if (clear) begin
      sel_d    = '0;
      shadow_d = '0;
      ovr_d    = 1'b0;
    end else if (accept) begin
      sel_d    = sel_q + SEL_W'(1);
      shadow_d = wr_word;
      if (done) begin
        shadow_d = '0;
        if (slot_free) begin
          word_d  = wr_word;
          state_d = HOLD;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      ovr_q    <= 1'b0;
      state_q  <= COLLECT;
    end else begin
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      ovr_q    <= ovr_d;
      state_q  <= state_d;
    end
  end

  assign output_lines = word_q;
  assign select_lines = sel_q;
  assign out_valid    = (state_q == HOLD);
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_demultiplexer_1_to_8_deserializer.sv
// Scoreboard bench for the 1-to-8 deserializer.
// Words expected are queued at send time and checked on presentation.
module tb_demultiplexer_1_to_8_deserializer;

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic       in_valid;
  logic       clear;
  logic       out_ready;
  logic [7:0] output_lines;
  logic [2:0] select_lines;
  logic       out_valid;
  logic       overrun;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_q[$];
  logic pv;
  logic pc;

  demultiplexer_1_to_8_deserializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .in_valid    (in_valid),
    .clear       (clear),
    .out_ready   (out_ready),
    .output_lines(output_lines),
    .select_lines(select_lines),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // A new word is on the bus when valid rises or follows a consume.
  initial begin
    pv = 1'b0;
    pc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        pc = 1'b0;
      end else begin
        if (out_valid && (!pv || pc)) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got %h, none expected",
                     output_lines);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (output_lines !== e) begin
              n_bad++;
              $display("FAIL sb_word: got %h, expected %h",
                       output_lines, e);
            end
          end
        end
        pv = out_valid;
        pc = out_valid && out_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    in_valid  = 1'b1;
    serial_in = b;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w,
                           input bit push);
    for (int i = 0; i < 8; i++) begin
      if (push && i == 7)
        exp_q.push_back(w);
      send_bit(w[i]);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_outs(input string nm,
                          input logic [7:0] eo,
                          input logic [2:0] es,
                          input logic ev,
                          input logic eovr);
    n_cmp++;
    if (output_lines !== eo || select_lines !== es ||
        out_valid !== ev || overrun !== eovr) begin
      n_bad++;
      $display("FAIL %s: got out=%h sel=%0d v=%b ovr=%b, expected out=%h sel=%0d v=%b ovr=%b",
               nm, output_lines, select_lines, out_valid,
               overrun, eo, es, ev, eovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    serial_in = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_outs("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_outs("reset_release", 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    bits = 8'b0101_1101;
    for (int i = 0; i < 8; i++) begin
      if (i == 7)
        exp_q.push_back(8'h5D);
      send_bit(bits[i]);
      if (i == 3)
        chk_outs("basic_mid", 8'h00, 3'd4, 1'b0, 1'b0);
    end
    chk_outs("basic_word", 8'h5D, 3'd0, 1'b1, 1'b0);
    consume();
    chk_outs("basic_consumed", 8'h5D, 3'd0, 1'b0, 1'b0);
    tick();
    chk_outs("basic_idle_ready", 8'h5D, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h5D;
    for (int i = 0; i < 3; i++)
      send_bit(w[i]);
    for (int g = 0; g < 2; g++) begin
      serial_in = ~serial_in;
      tick();
      chk_outs("gap_hold", 8'h5D, 3'd3, 1'b0, 1'b0);
    end
    for (int i = 3; i < 8; i++) begin
      if (i == 7)
        exp_q.push_back(w);
      send_bit(w[i]);
    end
    chk_outs("gap_word", 8'h5D, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(8'hFF, 1'b0);
    chk_outs("ovr_drop", 8'h5D, 3'd0, 1'b1, 1'b1);
    tick();
    chk_outs("ovr_sticky", 8'h5D, 3'd0, 1'b1, 1'b1);
    send_bit(1'b1);
    clear = 1'b1;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk_outs("ovr_clear", 8'h5D, 3'd0, 1'b1, 1'b0);
    consume();
    chk_outs("ovr_consumed", 8'h5D, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_word(8'h5D, 1'b1);
    chk_outs("b2b_first", 8'h5D, 3'd0, 1'b1, 1'b0);
    send_word(8'hA2, 1'b1);
    chk_outs("b2b_second", 8'hA2, 3'd0, 1'b1, 1'b0);
    tick();
    chk_outs("b2b_drain", 8'hA2, 3'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic test_complete_on_consume();
    logic [7:0] w;
    send_word(8'h11, 1'b1);
    w = 8'h22;
    for (int i = 0; i < 7; i++)
      send_bit(w[i]);
    chk_outs("coc_pending", 8'h11, 3'd7, 1'b1, 1'b0);
    out_ready = 1'b1;
    exp_q.push_back(w);
    send_bit(w[7]);
    out_ready = 1'b0;
    chk_outs("coc_swap", 8'h22, 3'd0, 1'b1, 1'b0);
    consume();
  endtask

  task automatic test_clear_mid();
    for (int i = 0; i < 3; i++)
      send_bit(1'b1);
    clear = 1'b1;
    in_valid = 1'b1;
    serial_in = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk_outs("clr_mid", 8'h22, 3'd0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b1);
    chk_outs("clr_word", 8'h3C, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++)
      send_bit(1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs("arst_now", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    send_word(8'h81, 1'b1);
    chk_outs("arst_word", 8'h81, 3'd0, 1'b1, 1'b0);
    consume();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_complete_on_consume();
    test_clear_mid();
    test_async_reset();
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d words never seen, expected 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demultiplexer_1_to_8_deserializer.md
Name: demultiplexer_1_to_8_deserializer

Overview:
- Receive end of the 8-to-1 serial-select path. Takes one serial bit per accepted cycle and routes it to output lane `select_lines`. An internal 3-bit index steps 0..7.
- Assembles 8 bits into a shadow word, then presents the completed word on `output_lines` with a valid/ready handshake.
- Pairs with a mux-based serializer that steps its select lines 000..111.

Parameters:
- WIDTH, 8, number of output lanes/bits per word. Must equal 2**SEL_W.
- SEL_W, 3, width of the lane index / select lines.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- serial_in  input  1  serial data bit.
- in_valid  input  1  serial_in is valid this cycle.
- clear  input  1  synchronous restart: index to 0, shadow to 0, overrun cleared.
- out_ready  input  1  consumer accepts output_lines.
- output_lines  output  WIDTH  last completed word.
- select_lines  output  SEL_W  lane the next valid bit will land in.
- out_valid  output  1  output_lines holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, async): output_lines=0, select_lines=0, out_valid=0, overrun=0, shadow=0.
- Priority per cycle: reset > clear > in_valid.
- clear=1:
  - select_lines=0, shadow=0, overrun=0.
  - out_valid and output_lines are unaffected; a pending word may still be consumed.
  - in_valid in the same cycle is ignored.
- Accepted bit (in_valid=1, clear=0):
  - shadow[select_lines] <= serial_in; other shadow bits unchanged.
  - select_lines <= select_lines+1, wrapping 7 -> 0.
  - Ordering is LSB-first: the k-th bit of a word lands in bit k (select 000 -> bit 0, matching the mux convention).
- in_valid=0: no state change (gaps allowed mid-word).
- Word completion: an accepted bit with select_lines==WIDTH-1. The completed word is the shadow with bit WIDTH-1 replaced by serial_in.
  - If slot is free (out_valid=0, or out_valid=1 with out_ready=1 this cycle):
    - output_lines <= completed word, out_valid <= 1 next cycle.
    - Latency: last bit accepted in cycle N -> word visible and out_valid=1 in cycle N+1.
  - If slot is busy (out_valid=1, out_ready=0):
    - Completed word is dropped; output_lines is unchanged.
    - overrun <= 1 (sticky until clear or reset).
    - Index still wraps to 0.
  - Shadow is zeroed on completion in both cases.
- Handshake: out_valid=1 and out_ready=1 with no completion that cycle -> out_valid <= 0; output_lines holds its value.
- out_ready with out_valid=0: no effect.
- Reset mid-word: partial bits are discarded; the next word starts at lane 0.
- Control is a 2-state FSM:
  - COLLECT: index counting.
  - HOLD: out_valid=1.
  - HOLD is orthogonal to the index, so it is implemented as the out_valid flag and the index counter; no extra states.

Decomposition:
- Shared package `demux_pkg`:
  - constants DEMUX_WIDTH=8 and DEMUX_SEL_W=3;
  - typedef sel_t (logic [SEL_W-1:0]);
  - typedef word_t (logic [WIDTH-1:0]).
- One natural sub-module: `demux_lane_decoder`, a combinational 1-to-WIDTH one-hot decode of select_lines gated by in_valid. It produces the per-bit write enables for the shadow register and is the structural inverse of the and/or mux.
- Counter, handshake and overrun logic stay in the top module.

Test Plan:
- Basic word: reset, then send bits 1,0,1,1,1,0,1,0 on consecutive cycles with in_valid=1 and out_ready=0 -> cycle after 8th bit: output_lines=8'b01011101 (0x5D), out_valid=1, select_lines=0, overrun=0.
- Gaps: same 8 bits with in_valid=0 for 2 cycles between bits 3 and 4 -> output_lines=0x5D. select_lines holds 3 during the gap.
- Overrun: after 0x5D pending with out_ready=0, send 0xFF -> output_lines stays 0x5D, overrun=1. Assert clear -> overrun=0, out_valid still 1.
- Back-to-back: out_ready=1 constantly, send 0x5D then 0xA2 with no gap -> out_valid high for 1 cycle with 0x5D, then 8 cycles later 0xA2; overrun=0. Completion coinciding with a consume keeps out_valid=1 with the new word.
- Clear mid-word: send 3 bits, assert clear with in_valid=1 -> select_lines=0 and that bit is ignored. Next 8 bits 0x3C -> output_lines=0x3C.
- Async reset mid-word: drop rst_n between clock edges after 5 bits -> all outputs 0 immediately, before the next clk edge. After release, 8 bits 0x81 -> output_lines=0x81.
